// File: rtl/fifo_buf_pkg.sv
// fifo_buf_pkg: sizing defaults and threshold helpers shared by the FIFO slice
package fifo_buf_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_AF_MARGIN = 1;
    localparam int DEF_AE_MARGIN = 1;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic int cnt_width(input int aw);
        return aw + 1;
    endfunction

    function automatic int af_level(input int aw, input int margin);
        return depth_of(aw) - margin;
    endfunction
endpackage

// File: rtl/data_mem.sv
// data_mem: simple dual-port RAM, registered read, read-before-write
module data_mem
    import fifo_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [depth_of(ADDR_WIDTH)];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // only the output register is reset; the array keeps its contents
    always_ff @(posedge clk) begin
        if (!reset) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/fifo_buf.sv
// fifo_buf: synchronous FIFO with occupancy, threshold flags and sticky error flags
module fifo_buf
    import fifo_buf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AF_MARGIN = DEF_AF_MARGIN,
    parameter int AE_MARGIN = DEF_AE_MARGIN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);
    localparam int CW = cnt_width(ADDR_WIDTH);
    localparam logic [CW-1:0] FULL_LVL = CW'(depth_of(ADDR_WIDTH));
    localparam logic [CW-1:0] AF_LVL = CW'(af_level(ADDR_WIDTH, AF_MARGIN));
    localparam logic [CW-1:0] AE_LVL = CW'(AE_MARGIN);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  pop_ok, push_ok;

    // a pop frees a slot in the same edge, so a full FIFO still accepts a push
    always_comb begin
        pop_ok = rd_en & ~empty;
        push_ok = wr_en & (~full | pop_ok);
    end

    assign full = count == FULL_LVL;
    assign empty = count == '0;
    assign almost_full = count >= AF_LVL;
    assign almost_empty = count <= AE_LVL;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(push_ok);
            rd_ptr <= rd_ptr + ADDR_WIDTH'(pop_ok);
            count <= count + CW'(push_ok) - CW'(pop_ok);
            rd_valid <= pop_ok;
            overflow <= (wr_en & ~push_ok) | (overflow & ~clr_err);
            underflow <= (rd_en & ~pop_ok) | (underflow & ~clr_err);
        end
    end

    data_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk(clk),
        .reset(reset),
        .wr_en(push_ok & reset),
        .wr_addr(wr_ptr),
        .wr_data(wr_data),
        .rd_en(pop_ok),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );
endmodule
